grad_bin_unit: RTL and testbench
================================

Name: grad_bin_unit

Overview:
Consumer (sink) end of the line buffer's kernel stream. Accepts 3x3 pixel windows over the kernel valid/ready handshake and computes central-difference gradients gx/gy. Emits per-pixel gradient magnitude and an unsigned 9-bin orientation index (0..180 deg) on a valid/ready stream to the HOG cell-histogram stage. Two-stage pipeline with full backpressure. No kernel is dropped or duplicated.

Parameters:
BUFFER_WIDTH, 8, pixel width in bits (unsigned).
BLOCK_WIDTH, 3, kernel columns; only 3 is supported (elaboration error otherwise).
BLOCK_HEIGHT, 3, kernel rows; only 3 is supported.
KERNEL_WIDTH, BLOCK_WIDTH*BLOCK_HEIGHT*BUFFER_WIDTH, kernel bus width (derived).
MAG_WIDTH, BUFFER_WIDTH+1, magnitude width (derived).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset, asynchronous, active-low.
k_valid  in  1  kernel bus holds a valid window.
k_border  in  1  window straddles a line border (qualified by k_valid).
kernel  in  KERNEL_WIDTH  window. P(r,c) = kernel[(r*BLOCK_WIDTH+c)*BUFFER_WIDTH +: BUFFER_WIDTH]. r=0 is the newest (bottom) row, r=2 the top row. c=0 is the oldest (left) column, c=2 the right column.
k_ready  out  1  this block accepts the window this cycle.
g_valid  out  1  output beat valid.
g_ready  in  1  downstream accepts the output.
g_mag  out  MAG_WIDTH  |gx|+|gy|, unsigned.
g_bin  out  4  orientation bin 0..8 (20 deg each).
g_border  out  1  beat derives from a border window.

Behaviour:
- Reset (rst=0, async): s1_valid=0, s2_valid=0, g_valid=0, g_mag=0, g_bin=0, g_border=0, k_ready=1. Reset mid-stream discards in-flight beats. The first accept after release needs no warm-up.
- Handshake: transfer in when k_valid&&k_ready; transfer out when g_valid&&g_ready.
- Payload stability: while g_valid&&!g_ready, g_mag, g_bin and g_border hold stable. g_valid never deasserts without a transfer.
- Stage 1 (accept), signed BUFFER_WIDTH+1 bits:
  - gx = P(1,2)-P(1,0)
  - gy = P(0,1)-P(2,1)
  - The border flag is registered alongside.
- Stage 2, fold: if gx<0 then gx'=-gx, gy'=-gy; else gx'=gx, gy'=gy. Let a=|gy'| and b=gx'.
- Stage 2, sector: k = count of T in {93,215,443,1452} (tan 20/40/60/80 deg in Q8) with a*256 >= b*T. Products are unsigned, 2*BUFFER_WIDTH+4 bits, no overflow.
- Stage 2, bin: g_bin = k if gy'>=0, else 8-k.
- Stage 2, magnitude: g_mag = |gx|+|gy|. Maximum 510; no saturation is needed.
- Degenerate case: gx=gy=0 gives mag 0 and bin 0.
- Border windows: forced to g_mag=0, g_bin=0, g_border=1. They are still emitted, so the raster count is preserved.
- Pipeline advance:
  - s2 loads when !s2_valid || g_ready.
  - s1 loads when !s1_valid || s2 loads.
  - k_ready = !s1_valid || s2 loads (combinational from g_ready).
- Latency and throughput: 2 cycles accept-to-g_valid. Throughput is 1 beat per cycle with g_ready held high.
- Capacity: holds at most 2 beats. With g_ready low, k_ready falls after 2 accepts.
- Simultaneous in+out on a full pipeline: all stages shift; no bubble, no loss.

Decomposition:
- Shared package (grad_pkg):
  - Q8 tan thresholds TAN20_Q8..TAN80_Q8.
  - NUM_BINS=9, BIN_WIDTH=4.
  - Function kernel_px(r,c) returning the bit offset.
- Sub-module: orient_bin, purely combinational. It takes gx, gy and produces bin, and can be unit-tested exhaustively over all gx/gy pairs.

Test Plan:
- Horizontal edge: P(1,0)=10, P(1,2)=50, P(0,1)=P(2,1)=20 -> g_mag=40, g_bin=0, g_border=0, g_valid exactly 2 cycles after accept.
- Vertical edge: P(0,1)=60, P(2,1)=30, gx=0 -> g_mag=30, g_bin=4.
- Fold path: gx=-20, gy=+20 (P(1,0)=40, P(1,2)=20, P(0,1)=30, P(2,1)=10) -> g_mag=40, g_bin=6. Also gx=-5, gy=0 -> g_bin=0.
- Backpressure: stream 6 kernels with g_ready=0 for cycles 0..7 -> exactly 2 accepted, k_ready=0 until g_ready=1. Payload is stable during the stall; all 6 emerge in order with no duplicates.
- Border: k_border=1 with gradients gx=100 -> g_mag=0, g_bin=0, g_border=1; the next non-border kernel is unaffected.
- Reset mid-stream: assert rst=0 with 2 beats in flight -> g_valid=0 and k_ready=1 immediately (async). After release, the first new kernel emerges 2 cycles after accept and no stale beat appears.

Source files
------------

// File: rtl/grad_pkg.sv
// Shared constants for the gradient/orientation path.
//   TANxx_Q8  : tan(20/40/60/80 deg) scaled by 256, used as sector thresholds
//   NUM_BINS  : unsigned orientation bins over 0..180 deg (20 deg each)
//   BIN_WIDTH : width of a bin index
//   kernel_px : bit offset of pixel P(r,c) inside a flattened 3x3 window
package grad_pkg;

    localparam int TAN20_Q8  = 93;
    localparam int TAN40_Q8  = 215;
    localparam int TAN60_Q8  = 443;
    localparam int TAN80_Q8  = 1452;

    localparam int NUM_BINS  = 9;
    localparam int BIN_WIDTH = 4;
    localparam int KBLK_W    = 3;

    // r=0 is the newest (bottom) row, c=0 the oldest (left) column.
    function automatic int kernel_px(input int r, input int c, input int bw = 8);
        return (r * KBLK_W + c) * bw;
    endfunction

endpackage

// File: rtl/grad_bin_unit_orient_bin.sv
// orient_bin: purely combinational unsigned-orientation binning.
//   i_gx, i_gy : signed gradients, GW bits (two's complement)
//   o_bin      : bin 0..NUM_BINS-1, 20 deg per bin over 0..180 deg
// The vector is folded into the right half-plane (gx >= 0) so only the
// first/fourth quadrants need resolving; the sector count k comes from
// comparing |gy|/gx against tan thresholds in Q8 without a divider.
module orient_bin
    import grad_pkg::*;
#(
    parameter int GW = 9
) (
    input  logic [GW-1:0]        i_gx,
    input  logic [GW-1:0]        i_gy,
    output logic [BIN_WIDTH-1:0] o_bin
);

    localparam int PW = 2 * (GW - 1) + 4;

    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic signed [GW-1:0] w_gxf;
    logic signed [GW-1:0] w_gyf;
    logic        [GW-1:0] w_a;
    logic        [GW-1:0] w_b;
    logic        [PW-1:0] w_a_sc;
    logic        [2:0]    w_k;

    assign w_gx  = $signed(i_gx);
    assign w_gy  = $signed(i_gy);

    // Fold by 180 deg when gx < 0; unsigned orientation is unchanged.
    assign w_gxf = w_gx[GW-1] ? -w_gx : w_gx;
    assign w_gyf = w_gx[GW-1] ? -w_gy : w_gy;
    assign w_b   = w_gxf;
    assign w_a   = w_gyf[GW-1] ? -w_gyf : w_gyf;
    assign w_a_sc = PW'(w_a) << 8;

    function automatic logic ge_tan(input logic [PW-1:0] a_sc,
                                    input logic [GW-1:0] b,
                                    input int            t);
        return a_sc >= (PW'(b) * PW'(t));
    endfunction

    assign w_k = 3'(ge_tan(w_a_sc, w_b, TAN20_Q8)) + 3'(ge_tan(w_a_sc, w_b, TAN40_Q8))
               + 3'(ge_tan(w_a_sc, w_b, TAN60_Q8)) + 3'(ge_tan(w_a_sc, w_b, TAN80_Q8));

    always_comb begin
        o_bin = '0;
        // A zero vector would otherwise pass every threshold (0 >= 0).
        if (w_gx == '0 && w_gy == '0)
            o_bin = '0;
        else if (!w_gyf[GW-1])
            o_bin = BIN_WIDTH'(w_k);
        else
            o_bin = BIN_WIDTH'(NUM_BINS - 1) - BIN_WIDTH'(w_k);
    end

endmodule

// File: rtl/grad_bin_unit.sv
// grad_bin_unit: sink of the 3x3 kernel stream; emits gradient magnitude
// and 9-bin unsigned orientation per window.
//   clk, rst       : clock, asynchronous active-low reset
//   k_valid/k_ready: kernel handshake; k_border flags line-border windows
//   kernel         : flattened window, P(r,c) at kernel_px(r,c)
//   g_valid/g_ready: output handshake
//   g_mag, g_bin   : |gx|+|gy| and orientation bin; g_border marks border beats
// Stage 1 registers central differences, stage 2 registers mag/bin.
// Each stage loads when empty or when the stage after it drains, giving
// full throughput with a two-beat capacity under backpressure.
module grad_bin_unit
    import grad_pkg::*;
#(
    parameter int BUFFER_WIDTH = 8,
    parameter int BLOCK_WIDTH  = 3,
    parameter int BLOCK_HEIGHT = 3,
    parameter int KERNEL_WIDTH = BLOCK_WIDTH * BLOCK_HEIGHT * BUFFER_WIDTH,
    parameter int MAG_WIDTH    = BUFFER_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    k_valid,
    input  logic                    k_border,
    input  logic [KERNEL_WIDTH-1:0] kernel,
    output logic                    k_ready,
    output logic                    g_valid,
    input  logic                    g_ready,
    output logic [MAG_WIDTH-1:0]    g_mag,
    output logic [BIN_WIDTH-1:0]    g_bin,
    output logic                    g_border
);

    localparam int GW = BUFFER_WIDTH + 1;

    if (BLOCK_WIDTH != 3 || BLOCK_HEIGHT != 3) begin : g_bad_geom
        $error("grad_bin_unit supports only 3x3 kernels");
    end

    logic [BUFFER_WIDTH-1:0] w_p10, w_p12, w_p01, w_p21;
    logic [GW-1:0]           w_gx, w_gy;
    logic                    w_s1_load, w_s2_load;
    logic [GW-1:0]           w_abs_gx, w_abs_gy;
    logic [MAG_WIDTH-1:0]    w_mag;
    logic [BIN_WIDTH-1:0]    w_bin;
    logic                    w_unused;

    logic                    r_s1_valid, r_s1_border;
    logic [GW-1:0]           r_s1_gx, r_s1_gy;
    logic                    r_s2_valid, r_border;
    logic [MAG_WIDTH-1:0]    r_mag;
    logic [BIN_WIDTH-1:0]    r_bin;

    assign w_p10 = kernel[kernel_px(1, 0, BUFFER_WIDTH) +: BUFFER_WIDTH];
    assign w_p12 = kernel[kernel_px(1, 2, BUFFER_WIDTH) +: BUFFER_WIDTH];
    assign w_p01 = kernel[kernel_px(0, 1, BUFFER_WIDTH) +: BUFFER_WIDTH];
    assign w_p21 = kernel[kernel_px(2, 1, BUFFER_WIDTH) +: BUFFER_WIDTH];
    // Corner and centre pixels do not contribute to central differences.
    assign w_unused = ^kernel;

    // One extra bit makes the difference of two unsigned pixels exact.
    assign w_gx = {1'b0, w_p12} - {1'b0, w_p10};
    assign w_gy = {1'b0, w_p01} - {1'b0, w_p21};

    assign w_s2_load = !r_s2_valid || g_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign k_ready   = w_s1_load;

    assign w_abs_gx = r_s1_gx[GW-1] ? -r_s1_gx : r_s1_gx;
    assign w_abs_gy = r_s1_gy[GW-1] ? -r_s1_gy : r_s1_gy;
    assign w_mag    = MAG_WIDTH'(w_abs_gx) + MAG_WIDTH'(w_abs_gy);

    orient_bin #(.GW(GW)) u_orient_bin (
        .i_gx  (r_s1_gx),
        .i_gy  (r_s1_gy),
        .o_bin (w_bin)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_gx     <= '0;
            r_s1_gy     <= '0;
            r_s2_valid  <= 1'b0;
            r_border    <= 1'b0;
            r_mag       <= '0;
            r_bin       <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid  <= k_valid;
                r_s1_border <= k_border;
                r_s1_gx     <= w_gx;
                r_s1_gy     <= w_gy;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                r_border   <= r_s1_border;
                // Border beats still flow so downstream raster counts line up.
                r_mag      <= r_s1_border ? '0 : w_mag;
                r_bin      <= r_s1_border ? '0 : w_bin;
            end
        end
    end

    assign g_valid  = r_s2_valid;
    assign g_mag    = r_mag;
    assign g_bin    = r_bin;
    assign g_border = r_border;

endmodule

// File: tb/tb_grad_bin_unit.sv
module tb_grad_bin_unit;

    localparam int BW = 8;
    localparam int KW = 9 * BW;
    localparam int MW = BW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          k_valid = 1'b0;
    logic          k_border = 1'b0;
    logic [KW-1:0] kernel = '0;
    logic          k_ready;
    logic          g_valid;
    logic          g_ready = 1'b1;
    logic [MW-1:0] g_mag;
    logic [3:0]    g_bin;
    logic          g_border;

    grad_bin_unit dut (
        .clk      (clk),
        .rst      (rst),
        .k_valid  (k_valid),
        .k_border (k_border),
        .kernel   (kernel),
        .k_ready  (k_ready),
        .g_valid  (g_valid),
        .g_ready  (g_ready),
        .g_mag    (g_mag),
        .g_bin    (g_bin),
        .g_border (g_border)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] mag;
        logic [3:0]    bin;
        logic          brd;
        logic          lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pop on each transfer, stall-hold check.
    logic          prev_stall = 1'b0;
    logic [MW-1:0] pm;
    logic [3:0]    pb;
    logic          pbr;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                assert (g_valid === 1'b1 && g_mag === pm && g_bin === pb && g_border === pbr) else begin
                    fails++;
                    $error("FAIL stall_hold: got v=%0b mag=%0d bin=%0d brd=%0b, want v=1 mag=%0d bin=%0d brd=%0b",
                           g_valid, g_mag, g_bin, g_border, pm, pb, pbr);
                end
            end
            if (g_valid && g_ready) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL spurious_beat: got mag=%0d bin=%0d brd=%0b, want no beat", g_mag, g_bin, g_border);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    tests += 3;
                    assert (g_mag === e.mag) else begin
                        fails++; $error("FAIL mag: got %0d want %0d", g_mag, e.mag);
                    end
                    assert (g_bin === e.bin) else begin
                        fails++; $error("FAIL bin: got %0d want %0d", g_bin, e.bin);
                    end
                    assert (g_border === e.brd) else begin
                        fails++; $error("FAIL border: got %0b want %0b", g_border, e.brd);
                    end
                    if (e.lat) begin
                        tests++;
                        assert (cyc - e.acc == 2) else begin
                            fails++; $error("FAIL latency: got %0d want 2", cyc - e.acc);
                        end
                    end
                end
            end
            prev_stall = g_valid && !g_ready;
            pm  = g_mag;
            pb  = g_bin;
            pbr = g_border;
        end
    end

    // Build a window; pixels that must not matter get distinct filler values.
    function automatic logic [KW-1:0] mk(input logic [7:0] p10, p12, p01, p21);
        logic [KW-1:0] k;
        for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'(163 + i * 37);
        k[(1*3+0)*8 +: 8] = p10;
        k[(1*3+2)*8 +: 8] = p12;
        k[(0*3+1)*8 +: 8] = p01;
        k[(2*3+1)*8 +: 8] = p21;
        return k;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] p10, p12, p01, p21, input logic brd,
                        input logic [3:0] ebin, input logic lat);
        exp_t e;
        int gx, gy;
        gx = int'(p12) - int'(p10);
        gy = int'(p01) - int'(p21);
        e.mag = brd ? '0 : MW'((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy));
        e.bin = brd ? 4'd0 : ebin;
        e.brd = brd;
        e.lat = lat;
        kernel   = mk(p10, p12, p01, p21);
        k_border = brd;
        k_valid  = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (k_ready) begin
                e.acc = cyc;
                @(posedge clk);
                sb.push_back(e);
                #1;
                k_valid  = 1'b0;
                k_border = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++;
        assert (k_ready === 1'b1) else begin
            fails++; $error("FAIL send_timeout: got k_ready=%0b want 1", k_ready);
        end
        k_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        tests += 5;
        assert (g_valid === 1'b0) else begin fails++; $error("FAIL rst_gvalid: got %0b want 0", g_valid); end
        assert (k_ready === 1'b1) else begin fails++; $error("FAIL rst_kready: got %0b want 1", k_ready); end
        assert (g_mag === '0)     else begin fails++; $error("FAIL rst_mag: got %0d want 0", g_mag); end
        assert (g_bin === 4'd0)   else begin fails++; $error("FAIL rst_bin: got %0d want 0", g_bin); end
        assert (g_border === 1'b0) else begin fails++; $error("FAIL rst_border: got %0b want 0", g_border); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed gradients (p10, p12, p01, p21)
        send(10,  50,  20,  20, 1'b0, 4'd0, 1'b1); // horizontal edge
        send(0,   0,   60,  30, 1'b0, 4'd4, 1'b1); // vertical edge
        send(40,  20,  30,  10, 1'b0, 4'd6, 1'b1); // fold gx=-20 gy=20
        send(5,   0,   0,   0,  1'b0, 4'd0, 1'b1); // fold gx=-5 gy=0
        send(0,   0,   0,   0,  1'b0, 4'd0, 1'b1); // degenerate
        send(0,   100, 100, 0,  1'b0, 4'd2, 1'b1); // 45 deg
        send(0,   10,  0,   100, 1'b0, 4'd4, 1'b1); // ~96 deg
        send(0,   100, 0,   30, 1'b0, 4'd8, 1'b1); // ~163 deg
        send(0,   255, 255, 0,  1'b0, 4'd2, 1'b1); // max magnitude
        send(255, 0,   0,   255, 1'b0, 4'd2, 1'b1); // max, folded
        send(0,   100, 40,  0,  1'b0, 4'd1, 1'b1); // ~22 deg
        send(100, 0,   40,  0,  1'b0, 4'd7, 1'b1); // ~158 deg
        send(0,   20,  100, 0,  1'b0, 4'd3, 1'b1); // ~79 deg
        // Border window then identical non-border window
        send(0,   100, 50,  50, 1'b1, 4'd0, 1'b1);
        send(0,   100, 50,  50, 1'b0, 4'd0, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Backpressure: only two beats fit while g_ready is low
        g_ready = 1'b0;
        send(10,  50,  20,  20, 1'b0, 4'd0, 1'b0);
        send(0,   0,   60,  30, 1'b0, 4'd4, 1'b0);
        kernel  = mk(40, 20, 30, 10);
        k_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            tests++;
            assert (k_ready === 1'b0 && g_valid === 1'b1) else begin
                fails++; $error("FAIL bp_full: got k_ready=%0b g_valid=%0b want 0/1", k_ready, g_valid);
            end
            @(posedge clk); #1;
        end
        g_ready = 1'b1;
        send(40,  20,  30,  10, 1'b0, 4'd6, 1'b1);
        send(0,   100, 100, 0,  1'b0, 4'd2, 1'b1);
        send(0,   100, 0,   30, 1'b0, 4'd8, 1'b1);
        send(0,   20,  100, 0,  1'b0, 4'd3, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Reset with two beats in flight
        g_ready = 1'b0;
        send(0,   255, 255, 0,  1'b0, 4'd2, 1'b0);
        send(0,   100, 40,  0,  1'b0, 4'd1, 1'b0);
        rst = 1'b0;
        #1;
        tests += 2;
        assert (g_valid === 1'b0) else begin fails++; $error("FAIL midrst_gvalid: got %0b want 0", g_valid); end
        assert (k_ready === 1'b1) else begin fails++; $error("FAIL midrst_kready: got %0b want 1", k_ready); end
        sb.delete();
        repeat (2) @(posedge clk); #1;
        rst     = 1'b1;
        g_ready = 1'b1;
        send(100, 0,   40,  0,  1'b0, 4'd7, 1'b1);

        // Drain and make sure nothing extra appears
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        tests++;
        assert (sb.size() == 0) else begin
            fails++; $error("FAIL drain: got %0d beats outstanding want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
